hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage core: drives the 2-bit `stall` codes consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC hold. It detects load-use and branch-operand hazards, redirect flushes, and data-memory wait states. A wait-state FSM with a timeout counter freezes the pipe until the memory acknowledges.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/hazard_perf.sv | 39 +++
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-register stall codes, the hazard
// controller's wait-state FSM encoding and a source/destination match helper.
package pipe_pkg;

    // Stall codes driven to every pipeline register
    localparam logic [1:0] STALL_RUN    = 2'b00;  // advance
    localparam logic [1:0] STALL_BUBBLE = 2'b01;  // clear, inserts a bubble
    localparam logic [1:0] STALL_FLUSH  = 2'b10;  // clear, squashes a wrong-path fetch
    localparam logic [1:0] STALL_HOLD   = 2'b11;  // keep current contents

    // Data-memory wait-state FSM
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_MWAIT = 1'b1
    } hz_state_t;

    localparam int WAIT_CNT_W = 8;

    // True when a used ID source matches a producer's destination.
    // Register 0 is hard-wired to zero and never produces a hazard.
    function automatic logic src_match(input logic [4:0] src,
                                       input logic       src_used,
                                       input logic [4:0] dst);
        return src_used && (dst != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_perf.sv
// Saturating 32-bit event counters for the hazard controller: bubble,
// flush and freeze cycles. Only built when HAZARD_PERF_EN is defined.
module hazard_perf
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_bubble,
    input  logic        i_flush,
    input  logic        i_wait,
    output logic [31:0] o_perf_bubble,
    output logic [31:0] o_perf_flush,
    output logic [31:0] o_perf_wait
);

    logic [2:0]  w_event;
    logic [31:0] r_cnt [3];

    assign w_event = {i_wait, i_flush, i_bubble};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            // Count one event class per cycle, sticking at all-ones
            always_ff @(posedge clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt[gi] <= '0;
                end else if (w_event[gi] && (r_cnt[gi] != '1)) begin
                    r_cnt[gi] <= r_cnt[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign o_perf_bubble = r_cnt[0];
    assign o_perf_flush  = r_cnt[1];
    assign o_perf_wait   = r_cnt[2];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage core.
// Detects load-use and branch-operand hazards, taken-branch redirects and
// data-memory wait states, and drives the stall codes of the four pipeline
// registers plus the PC hold. A RUN/MWAIT FSM with a timeout counter freezes
// the pipe until memory acknowledges or the wait is forcibly released.
// Optional feature macro: HAZARD_PERF_EN adds perf_bubble/perf_flush/perf_wait.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_branch,
    input  logic       id_branch_taken,
    input  logic       ex_RegWrite,
    input  logic       ex_MemtoReg,
    input  logic [4:0] ex_wreg,
    input  logic       mem_MemtoReg,
    input  logic [4:0] mem_wreg,
    input  logic       dmem_req,
    input  logic       dmem_ack,
    output logic       pc_stall,
    output logic [1:0] if_id_stall,
    output logic [1:0] id_ex_stall,
    output logic [1:0] ex_mem_stall,
    output logic [1:0] mem_wb_stall,
    output logic       mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_bubble,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_wait
`endif
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

    hz_state_t             r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_mem_err;

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_load_use;
    logic w_br_haz;
    logic w_timeout;
    logic w_release;
    logic w_freeze;
    logic w_bubble;
    logic w_flush;

    // Hazard detection against the EX and MEM producers
    always_comb begin
        w_hit_ex   = src_match(id_rs, id_use_rs, ex_wreg)  | src_match(id_rt, id_use_rt, ex_wreg);
        w_hit_mem  = src_match(id_rs, id_use_rs, mem_wreg) | src_match(id_rt, id_use_rt, mem_wreg);
        w_load_use = ex_MemtoReg & ex_RegWrite & w_hit_ex;
        w_br_haz   = id_branch & ((ex_RegWrite & w_hit_ex) | (mem_MemtoReg & w_hit_mem));
    end

    // Freeze resolution: an ack or a timeout in MWAIT releases the pipe this
    // very cycle, so that cycle falls through to the non-freeze rules
    always_comb begin
        w_timeout = (r_wait_cnt == TIMEOUT_CNT);
        w_release = (r_state == ST_MWAIT) & (dmem_ack | w_timeout);
        w_freeze  = ((r_state == ST_MWAIT) & ~w_release) |
                    ((r_state == ST_RUN) & dmem_req & ~dmem_ack);
        w_bubble  = ~w_freeze & (w_load_use | w_br_haz);
        w_flush   = ~w_freeze & ~(w_load_use | w_br_haz) & id_branch_taken;
    end

    // Stall code generation in priority order; reset forces every register clear
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = STALL_RUN;
        id_ex_stall  = STALL_RUN;
        ex_mem_stall = STALL_RUN;
        mem_wb_stall = STALL_RUN;
        if (!rst) begin
            pc_stall     = 1'b1;
            if_id_stall  = STALL_BUBBLE;
            id_ex_stall  = STALL_BUBBLE;
            ex_mem_stall = STALL_BUBBLE;
            mem_wb_stall = STALL_BUBBLE;
        end else if (w_freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = STALL_HOLD;
            id_ex_stall  = STALL_HOLD;
            ex_mem_stall = STALL_HOLD;
            mem_wb_stall = STALL_BUBBLE;
        end else if (w_bubble) begin
            pc_stall     = 1'b1;
            if_id_stall  = STALL_HOLD;
            id_ex_stall  = STALL_BUBBLE;
        end else if (w_flush) begin
            if_id_stall  = STALL_FLUSH;
        end
    end

    // Wait-state FSM with timeout counter and registered error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_mem_err <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (dmem_req && !dmem_ack) begin
                        r_state    <= ST_MWAIT;
                        r_wait_cnt <= WAIT_CNT_W'(1);
                    end
                end
                ST_MWAIT: begin
                    // A dropped request is ignored: only ack or timeout ends the wait
                    if (dmem_ack) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign mem_err = r_mem_err;

`ifdef HAZARD_PERF_EN
    hazard_perf u_perf (
        .clk           (clk),
        .i_rst_n       (rst),
        .i_bubble      (w_bubble),
        .i_flush       (w_flush),
        .i_wait        (w_freeze),
        .o_perf_bubble (perf_bubble),
        .o_perf_flush  (perf_flush),
        .o_perf_wait   (perf_wait)
    );
`endif

endmodule
